// File: rtl/result_serializer.sv
// result_serializer
//   Captures a multi-byte result frame and sends it out one byte at a time
//   over a valid/ready byte stream, least significant byte first.
//
// Ports
//   clk          : single clock, all state updates on its rising edge
//   rst_n        : synchronous active-low reset
//   ena          : global enable; when low every register holds
//   result       : NUM_BYTES*BYTE_W bit frame to serialize
//   result_valid : result is valid this cycle
//   byte_ready   : downstream accepts byte_out this cycle
//   clr_ovf      : clears the sticky overflow flag
//   byte_out     : current serialized byte (0 outside SEND)
//   byte_valid   : byte_out holds a valid byte
//   byte_last    : byte_out is the final byte of the frame
//   busy         : a frame is being transmitted
//   frame_done   : one-cycle pulse after the final byte is accepted
//   overflow     : sticky, set when a result arrived while busy and was dropped
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame held; waiting for result_valid
// SEND   | presenting byte idx_q of the captured frame
// DONE   | final byte accepted; frame_done pulse; may capture next frame

module result_serializer #(
  parameter int NUM_BYTES = 9,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [NUM_BYTES*BYTE_W-1:0] result,
  input  logic                        result_valid,
  input  logic                        byte_ready,
  input  logic                        clr_ovf,
  output logic [BYTE_W-1:0]           byte_out,
  output logic                        byte_valid,
  output logic                        byte_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int FRAME_W = NUM_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [FRAME_W-1:0] captured_q;
  logic               capture;
  logic               drop;
  logic               overflow_q;

  logic [BYTE_W-1:0] frame_bytes [NUM_BYTES];

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bytes
    assign frame_bytes[g] = captured_q[g*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic. With ena low nothing may change, so every decision
  // is gated on ena and the defaults keep the current values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    drop    = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (result_valid) begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          // An arriving result cannot preempt the in-flight frame.
          drop = result_valid;
          if (byte_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (result_valid) begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      captured_q <= '0;
    end else if (ena) begin
      idx_q <= idx_d;
      if (capture) begin
        captured_q <= result;
      end
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (ena) begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Outputs decode directly from registered state, so they hold whenever
  // the registers hold (ena low) and clear together with reset.
  always_comb begin
    byte_out   = '0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      SEND: begin
        byte_out   = frame_bytes[idx_q];
        byte_valid = 1'b1;
        byte_last  = (idx_q == LAST_IDX);
        busy       = 1'b1;
      end
      DONE: begin
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [71:0] result;
  logic        result_valid;
  logic        byte_ready;
  logic        clr_ovf;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [71:0] frame_a;
  logic [71:0] frame_b;

  result_serializer #(.NUM_BYTES(9), .BYTE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .result      (result),
    .result_valid(result_valid),
    .byte_ready  (byte_ready),
    .clr_ovf     (clr_ovf),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [71:0] f, input int k);
    byte_of = f[k*8 +: 8];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; result_valid = 1'b1; result = frame_a;
    tick(); tick();
    total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte_out got=%h exp=00", byte_out); end
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
    total++; if (byte_last !== 1'b0) begin bad++; $display("FAIL reset_byte_last got=%b exp=0", byte_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1; ena = 1'b1; result_valid = 1'b0; result = '0;
    tick();
    total++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b valid=%b exp=0,0", busy, byte_valid); end
  endtask

  task automatic test_basic();
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0; result = '0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (byte_out !== byte_of(frame_a, k) || byte_valid !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL basic_byte k=%0d got=%h/%b/%b exp=%h/1/1", k, byte_out, byte_valid, busy, byte_of(frame_a, k));
      end
      total++;
      if (byte_last !== (k == 8)) begin bad++; $display("FAIL basic_last k=%0d got=%b exp=%b", k, byte_last, (k == 8)); end
      tick();
    end
    total++;
    if (frame_done !== 1'b1 || byte_valid !== 1'b0 || busy !== 1'b0 || byte_out !== 8'h00) begin
      bad++; $display("FAIL basic_done done=%b valid=%b busy=%b out=%h exp=1,0,0,00", frame_done, byte_valid, busy, byte_out);
    end
    tick();
    total++; if (frame_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle done=%b busy=%b exp=0,0", frame_done, busy); end
  endtask

  task automatic test_backpressure();
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) begin
        byte_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          total++;
          if (byte_out !== 8'h04 || byte_valid !== 1'b1 || byte_last !== 1'b0) begin
            bad++; $display("FAIL bp_hold s=%0d got=%h/%b/%b exp=04/1/0", s, byte_out, byte_valid, byte_last);
          end
          tick();
        end
        byte_ready = 1'b1;
      end
      total++;
      if (byte_out !== byte_of(frame_a, k) || byte_valid !== 1'b1 || byte_last !== (k == 8)) begin
        bad++; $display("FAIL bp_byte k=%0d got=%h/%b/%b exp=%h/1/%b", k, byte_out, byte_valid, byte_last, byte_of(frame_a, k), (k == 8));
      end
      tick();
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", frame_done); end
    tick();
  endtask

  task automatic test_overflow();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_initial got=%b exp=0", overflow); end
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (byte_out !== byte_of(frame_a, k) || byte_valid !== 1'b1) begin
        bad++; $display("FAIL ovf_byte k=%0d got=%h/%b exp=%h/1", k, byte_out, byte_valid, byte_of(frame_a, k));
      end
      if (k == 4) begin result = frame_b; result_valid = 1'b1; end
      tick();
      result_valid = 1'b0; result = '0;
      if (k == 4) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      end
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b exp=1", frame_done); end
    tick();
    for (int s = 0; s < 3; s++) begin
      total++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin bad++; $display("FAIL ovf_no_resend s=%0d busy=%b valid=%b exp=0,0", s, busy, byte_valid); end
      tick();
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // Drop, then drop together with clear (set wins), then plain clear.
    result = frame_a; result_valid = 1'b1;
    tick();
    result = frame_b; result_valid = 1'b1;
    tick();
    total++; if (overflow !== 1'b1 || byte_out !== 8'h02) begin bad++; $display("FAIL ovf_drop2 ovf=%b out=%h exp=1,02", overflow, byte_out); end
    clr_ovf = 1'b1;
    tick();
    total++; if (overflow !== 1'b1 || byte_out !== 8'h03) begin bad++; $display("FAIL ovf_set_wins ovf=%b out=%h exp=1,03", overflow, byte_out); end
    result_valid = 1'b0; result = '0;
    tick();
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0 || byte_out !== 8'h04) begin bad++; $display("FAIL ovf_clear2 ovf=%b out=%h exp=0,04", overflow, byte_out); end
    for (int k = 3; k < 9; k++) begin
      total++;
      if (byte_out !== byte_of(frame_a, k)) begin bad++; $display("FAIL ovf_rest k=%0d got=%h exp=%h", k, byte_out, byte_of(frame_a, k)); end
      tick();
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ovf_done2 got=%b exp=1", frame_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_a k=%0d got=%b exp=1", k, busy); end
      tick();
    end
    total++; if (frame_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done done=%b busy=%b exp=1,0", frame_done, busy); end
    result = frame_b; result_valid = 1'b1;
    tick();
    result_valid = 1'b0; result = '0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (byte_out !== byte_of(frame_b, k) || byte_valid !== 1'b1 || busy !== 1'b1 || byte_last !== (k == 8) || frame_done !== 1'b0) begin
        bad++; $display("FAIL b2b_byte k=%0d got=%h/%b/%b/%b/%b exp=%h/1/1/%b/0", k, byte_out, byte_valid, busy, byte_last, frame_done, byte_of(frame_b, k), (k == 8));
      end
      tick();
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done_b got=%b exp=1", frame_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (byte_out !== byte_of(frame_a, k)) begin bad++; $display("FAIL rstmid_byte k=%0d got=%h exp=%h", k, byte_out, byte_of(frame_a, k)); end
      if (k < 5) tick();
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (byte_out !== 8'h00 || byte_valid !== 1'b0 || byte_last !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rstmid_zero got=%h/%b/%b/%b/%b/%b exp=00/0/0/0/0/0", byte_out, byte_valid, byte_last, busy, frame_done, overflow);
    end
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++; if (frame_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_done s=%0d done=%b busy=%b exp=0,0", s, frame_done, busy); end
    end
    result = frame_b; result_valid = 1'b1;
    tick();
    result_valid = 1'b0; result = '0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (byte_out !== byte_of(frame_b, k) || byte_valid !== 1'b1) begin
        bad++; $display("FAIL rstmid_new k=%0d got=%h/%b exp=%h/1", k, byte_out, byte_valid, byte_of(frame_b, k));
      end
      tick();
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rstmid_done got=%b exp=1", frame_done); end
    tick();
  endtask

  task automatic test_enable_freeze();
    result = frame_a; result_valid = 1'b1; byte_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin
        ena = 1'b0;
        for (int s = 0; s < 5; s++) begin
          total++;
          if (byte_out !== 8'h03 || byte_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL frz_hold s=%0d got=%h/%b/%b exp=03/1/1", s, byte_out, byte_valid, busy);
          end
          tick();
        end
        ena = 1'b1;
      end
      total++;
      if (byte_out !== byte_of(frame_a, k)) begin bad++; $display("FAIL frz_byte k=%0d got=%h exp=%h", k, byte_out, byte_of(frame_a, k)); end
      tick();
    end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL frz_done got=%b exp=1", frame_done); end
    ena = 1'b0;
    tick(); tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL frz_done_hold got=%b exp=1", frame_done); end
    ena = 1'b1;
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frz_done_end got=%b exp=0", frame_done); end
  endtask

  initial begin
    frame_a = 72'h090807060504030201;
    frame_b = 72'h998877665544332211;
    rst_n = 1'b0; ena = 1'b1; result = '0; result_valid = 1'b0;
    byte_ready = 1'b1; clr_ovf = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_enable_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
